// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter for the shared DDR read-burst channel between the I-cache and D-cache.
// Steers returned beats into the granted cache's FIFO and flags overflow and stalled bursts.
module ddr_rd_arbiter #(
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH     = 30,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
  input  logic [7:0]                ins_read_len,
  output logic                      ins_reading,
  input  logic                      data_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
  input  logic [7:0]                data_read_len,
  output logic                      data_reading,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [7:0]                rd_burst_len,
  input  logic                      rd_burst_ack,
  input  logic                      rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]     rd_burst_data,
  output logic                      ic_fifo_wr_en,
  output logic [DATA_WIDTH+8:0]     ic_fifo_din,
  input  logic                      ic_fifo_full,
  output logic                      dc_fifo_wr_en,
  output logic [DATA_WIDTH+8:0]     dc_fifo_din,
  input  logic                      dc_fifo_full,
  output logic                      overflow_err,
  output logic                      timeout_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StBurst, StDone} state_e;

  state_e           state_q;
  logic             last_grant_q;  // 1: data cache was granted last
  logic [8:0]       len_q;
  logic [7:0]       beat_idx_q;
  logic [WdW-1:0]   wd_q;

  logic                  grant_ins;
  logic [7:0]            sel_len;
  logic                  last_beat;
  logic                  beat_full;
  logic [DATA_WIDTH+8:0] din_w;

  // Instruction wins when alone, or on a tie when data was served last.
  assign grant_ins = ins_read_req & (~data_read_req | last_grant_q);
  assign sel_len   = grant_ins ? ins_read_len : data_read_len;
  assign last_beat = ({1'b0, beat_idx_q} == (len_q - 9'd1));
  assign beat_full = ins_reading ? ic_fifo_full : dc_fifo_full;
  assign din_w     = {rd_burst_data, beat_idx_q, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      len_q         <= '0;
      beat_idx_q    <= '0;
      wd_q          <= '0;
      ins_reading   <= 1'b0;
      data_reading  <= 1'b0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      ic_fifo_wr_en <= 1'b0;
      dc_fifo_wr_en <= 1'b0;
      ic_fifo_din   <= '0;
      dc_fifo_din   <= '0;
      overflow_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      ic_fifo_wr_en <= 1'b0;
      dc_fifo_wr_en <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ins_read_req || data_read_req) begin
            ins_reading   <= grant_ins;
            data_reading  <= ~grant_ins;
            rd_burst_addr <= grant_ins ? ins_read_addr : data_read_addr;
            rd_burst_len  <= sel_len;
            len_q         <= (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
            rd_burst_req  <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          if (rd_burst_ack) begin
            rd_burst_req <= 1'b0;
            beat_idx_q   <= '0;
            wd_q         <= '0;
            state_q      <= StBurst;
          end
        end
        StBurst: begin
          if (rd_burst_data_valid) begin
            ic_fifo_wr_en <= ins_reading;
            dc_fifo_wr_en <= data_reading;
            if (ins_reading) ic_fifo_din <= din_w;
            if (data_reading) dc_fifo_din <= din_w;
            if (beat_full) overflow_err <= 1'b1;
            beat_idx_q <= beat_idx_q + 8'd1;
            wd_q       <= '0;
            if (last_beat) state_q <= StDone;
          end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state_q     <= StDone;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StDone: begin
          ins_reading  <= 1'b0;
          data_reading <= 1'b0;
          last_grant_q <= data_reading;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed self-checking bench for ddr_rd_arbiter; the watchdog is shortened to 16 cycles.
module tb_ddr_rd_arbiter;

  localparam int AW = 28;
  localparam int DW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          ins_read_req, data_read_req;
  logic [AW-1:0] ins_read_addr, data_read_addr;
  logic [7:0]    ins_read_len, data_read_len;
  logic          ins_reading, data_reading;
  logic          rd_burst_req, rd_burst_ack, rd_burst_data_valid;
  logic [AW-1:0] rd_burst_addr;
  logic [7:0]    rd_burst_len;
  logic [DW-1:0] rd_burst_data;
  logic          ic_fifo_wr_en, dc_fifo_wr_en, ic_fifo_full, dc_fifo_full;
  logic [DW+8:0] ic_fifo_din, dc_fifo_din;
  logic          overflow_err, timeout_err;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  ddr_rd_arbiter #(
    .DDR_ADDR_WIDTH(AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ins_read_req       (ins_read_req),
    .ins_read_addr      (ins_read_addr),
    .ins_read_len       (ins_read_len),
    .ins_reading        (ins_reading),
    .data_read_req      (data_read_req),
    .data_read_addr     (data_read_addr),
    .data_read_len      (data_read_len),
    .data_reading       (data_reading),
    .rd_burst_req       (rd_burst_req),
    .rd_burst_addr      (rd_burst_addr),
    .rd_burst_len       (rd_burst_len),
    .rd_burst_ack       (rd_burst_ack),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .ic_fifo_wr_en      (ic_fifo_wr_en),
    .ic_fifo_din        (ic_fifo_din),
    .ic_fifo_full       (ic_fifo_full),
    .dc_fifo_wr_en      (dc_fifo_wr_en),
    .dc_fifo_din        (dc_fifo_din),
    .dc_fifo_full       (dc_fifo_full),
    .overflow_err       (overflow_err),
    .timeout_err        (timeout_err)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, rd_burst_req, 0);
    chk({tag, "_ins_rd"}, ins_reading, 0);
    chk({tag, "_data_rd"}, data_reading, 0);
    chk({tag, "_addr"}, rd_burst_addr, 0);
    chk({tag, "_len"}, rd_burst_len, 0);
    chk({tag, "_ic_we"}, ic_fifo_wr_en, 0);
    chk({tag, "_dc_we"}, dc_fifo_wr_en, 0);
    chk({tag, "_ic_din"}, ic_fifo_din, 0);
    chk({tag, "_dc_din"}, dc_fifo_din, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  // Acks the pending request, then delivers n back-to-back beats; returns in the DONE cycle.
  task automatic do_burst(input bit ins, input int n, input logic [DW-1:0] seed,
                          input int full_beat);
    rd_burst_ack = 1'b1;
    tick();
    rd_burst_ack = 1'b0;
    chk("req_drop", rd_burst_req, 0);
    for (int i = 0; i < n; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = seed + DW'(i);
      ic_fifo_full        = ins && (i == full_beat);
      dc_fifo_full        = !ins && (i == full_beat);
      if (i == full_beat) exp_ovf = 1'b1;
      tick();
      chk("wr_en", ins ? ic_fifo_wr_en : dc_fifo_wr_en, 1);
      chk("other_wr_en", ins ? dc_fifo_wr_en : ic_fifo_wr_en, 0);
      chk("din", ins ? ic_fifo_din : dc_fifo_din, {seed + DW'(i), 8'(i), 1'b1});
      chk("ovf", overflow_err, exp_ovf);
    end
    rd_burst_data_valid = 1'b0;
    ic_fifo_full        = 1'b0;
    dc_fifo_full        = 1'b0;
    chk("reading_in_done", ins ? ins_reading : data_reading, 1);
  endtask

  initial begin
    rst = 1'b1;
    ins_read_req = 1'b0; data_read_req = 1'b0;
    ins_read_addr = '0; data_read_addr = '0;
    ins_read_len = '0; data_read_len = '0;
    rd_burst_ack = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_data = '0;
    ic_fifo_full = 1'b0; dc_fifo_full = 1'b0;
    tick(2);
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // Single instruction read, with a stray beat during ISSUE.
    ins_read_req = 1'b1; ins_read_addr = 28'h100; ins_read_len = 8'd4;
    tick();
    chk("t1_ins_rd", ins_reading, 1);
    chk("t1_data_rd", data_reading, 0);
    chk("t1_req", rd_burst_req, 1);
    chk("t1_addr", rd_burst_addr, 28'h100);
    chk("t1_len", rd_burst_len, 4);
    ins_read_req = 1'b0;
    rd_burst_data_valid = 1'b1; rd_burst_data = 30'h3fff_0000;
    tick();
    rd_burst_data_valid = 1'b0;
    chk("t1_req_hold", rd_burst_req, 1);
    chk("t1_stray_beat", ic_fifo_wr_en, 0);
    do_burst(1'b1, 4, 30'h0000_0d00, -1);
    tick();
    chk("t1_ins_rd_low", ins_reading, 0);
    chk("t1_ic_we_low", ic_fifo_wr_en, 0);

    // Simultaneous requests from reset: ins, data, ins.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ins_read_req = 1'b1; ins_read_addr = 28'h200; ins_read_len = 8'd1;
    data_read_req = 1'b1; data_read_addr = 28'h300; data_read_len = 8'd2;
    tick();
    chk("t2_ins_first", ins_reading, 1);
    chk("t2_data_wait", data_reading, 0);
    chk("t2_addr_ins", rd_burst_addr, 28'h200);
    ins_read_addr = 28'h999;
    tick();
    chk("t2_addr_latched", rd_burst_addr, 28'h200);
    do_burst(1'b1, 1, 30'h0000_2000, -1);
    tick();
    chk("t2_idle_gap", data_reading | ins_reading, 0);
    tick();
    chk("t2_data_next", data_reading, 1);
    chk("t2_ins_off", ins_reading, 0);
    chk("t2_addr_data", rd_burst_addr, 28'h300);
    chk("t2_len_data", rd_burst_len, 2);
    do_burst(1'b0, 2, 30'h0000_3000, -1);
    tick(2);
    chk("t2_ins_again", ins_reading, 1);
    chk("t2_addr_new", rd_burst_addr, 28'h999);
    ins_read_req = 1'b0; data_read_req = 1'b0;
    do_burst(1'b1, 1, 30'h0000_4000, -1);
    tick();

    // Length 0 means 256 beats.
    data_read_req = 1'b1; data_read_addr = 28'h400; data_read_len = 8'd0;
    tick();
    chk("t3_data_rd", data_reading, 1);
    chk("t3_len", rd_burst_len, 0);
    data_read_req = 1'b0;
    do_burst(1'b0, 256, 30'h0100_0000, -1);
    chk("t3_tmo", timeout_err, 0);
    tick();
    chk("t3_data_rd_low", data_reading, 0);

    // Overflow on beat 2 of a 4-beat burst.
    ins_read_req = 1'b1; ins_read_addr = 28'h500; ins_read_len = 8'd4;
    tick();
    chk("t4_ins_rd", ins_reading, 1);
    chk("t4_ovf_pre", overflow_err, 0);
    ins_read_req = 1'b0;
    do_burst(1'b1, 4, 30'h0000_5000, 2);
    tick();
    chk("t4_ovf_sticky", overflow_err, 1);

    // Stall: 1 beat of 8, data request queued behind it.
    ins_read_req = 1'b1; ins_read_addr = 28'h600; ins_read_len = 8'd8;
    tick();
    chk("t5_ins_rd", ins_reading, 1);
    ins_read_req = 1'b0;
    data_read_req = 1'b1; data_read_addr = 28'h700; data_read_len = 8'd3;
    rd_burst_ack = 1'b1;
    tick();
    rd_burst_ack = 1'b0;
    rd_burst_data_valid = 1'b1; rd_burst_data = 30'h0000_6000;
    tick();
    rd_burst_data_valid = 1'b0;
    chk("t5_beat", ic_fifo_wr_en, 1);
    tick(15);
    chk("t5_tmo_early", timeout_err, 0);
    chk("t5_still_rd", ins_reading, 1);
    tick();
    chk("t5_tmo", timeout_err, 1);
    chk("t5_rd_in_done", ins_reading, 1);
    tick();
    chk("t5_ins_rd_low", ins_reading, 0);
    tick();
    chk("t5_data_granted", data_reading, 1);
    chk("t5_data_addr", rd_burst_addr, 28'h700);

    // Reset mid-burst, with a beat and an instruction request pending.
    data_read_req = 1'b0;
    rd_burst_ack = 1'b1;
    tick();
    rd_burst_ack = 1'b0;
    rd_burst_data_valid = 1'b1; rd_burst_data = 30'h0000_7000;
    tick();
    chk("t6_beat", dc_fifo_wr_en, 1);
    rst = 1'b1;
    ins_read_req = 1'b1; ins_read_addr = 28'h800; ins_read_len = 8'd2;
    tick();
    chk_reset("t6_rst");
    rst = 1'b0;
    rd_burst_data_valid = 1'b0;
    tick();
    chk("t6_ins_granted", ins_reading, 1);
    chk("t6_req", rd_burst_req, 1);
    chk("t6_addr", rd_burst_addr, 28'h800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Arbitrates the single DDR read-burst channel between the instruction cache and the data cache. It grants one requester at a time with round-robin fairness, drives the burst request to the DDR interface, and steers returned beats into the granted requester's FIFO as packed `{data, beat_index, valid}` words. It also watches each burst for stalls and for overflow of the destination FIFO.

## Interface
- `DDR_ADDR_WIDTH`, 28, DDR byte-address width
- `DATA_WIDTH`, 30, burst beat width (equals ISA_WIDTH)
- `TIMEOUT_CYCLES`, 1024, maximum idle cycles between beats before an abort
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `ins_read_req`  in  1  instruction-cache request, level
- `ins_read_addr`  in  DDR_ADDR_WIDTH  instruction burst start address
- `ins_read_len`  in  8  instruction burst length in beats; 0 means 256
- `ins_reading`  out  1  instruction burst in progress (grant)
- `data_read_req`, `data_read_addr`, `data_read_len`, `data_reading`: same meaning and widths for the data cache
- `rd_burst_req`  out  1  burst request to the DDR interface
- `rd_burst_addr`  out  DDR_ADDR_WIDTH  latched address of the granted requester
- `rd_burst_len`  out  8  latched length of the granted requester
- `rd_burst_ack`  in  1  DDR interface accepted the request
- `rd_burst_data_valid`  in  1  beat valid
- `rd_burst_data`  in  DATA_WIDTH  beat data
- `ic_fifo_wr_en`, `dc_fifo_wr_en`  out  1  destination FIFO write strobes
- `ic_fifo_din`, `dc_fifo_din`  out  DATA_WIDTH+9  `{data, beat_index[7:0], 1'b1}`
- `ic_fifo_full`, `dc_fifo_full`  in  1  destination FIFO full
- `overflow_err`  out  1  sticky: a beat was written while its destination FIFO was full
- `timeout_err`  out  1  sticky: a burst was aborted by the watchdog

## Operation
- States: IDLE, ISSUE, BURST, DONE.
- **IDLE**
  - One request pending: grant it.
  - Both pending: grant the one not in `last_grant`.
  - `last_grant` resets to DATA, so the instruction cache wins the first tie.
  - On grant: latch addr and len (len 0 is stored as 256 in a 9-bit counter), set the grant one-hot, go to ISSUE.
- **ISSUE**
  - Hold `rd_burst_req` = 1 with the latched addr and len.
  - On `rd_burst_ack`: drop the request and go to BURST.
- **BURST**
  - Each `rd_burst_data_valid` beat writes the granted FIFO only; `beat_index` starts at 0 and increments by 1.
  - If the beat arrives while that FIFO is full, still assert `wr_en` and set `overflow_err`.
  - When `beat_index` reaches len-1 and that beat is valid, go to DONE.
  - Watchdog: counts cycles without a beat and clears on every beat. At TIMEOUT_CYCLES it sets `timeout_err` and goes to DONE.
- **DONE**
  - Drop the grant, update `last_grant`, return to IDLE.
  - The same requester cannot be re-granted in this cycle.
- A request that drops while its burst is in flight does not abort the burst.
- Beats arriving outside BURST are discarded; no `wr_en` is asserted.
- Addr and len changes after grant are ignored until the next grant.

## Timing
- Reset: all outputs are 0, state is IDLE, counters are 0, `last_grant` is DATA, and both sticky errors clear. Reset mid-burst abandons the burst immediately, with no DONE cycle.
- Request in IDLE at cycle N:
  - `*_reading` and `rd_burst_req` are high from N+1.
  - `rd_burst_req` falls the cycle after `ack` is sampled.
- Beat with valid at cycle M: `*_fifo_wr_en` and `din` are registered and appear at M+1 (one-cycle latency).
- Last beat at cycle M: DONE at M+1, `*_reading` low at M+2, next grant visible at M+3 at the earliest.
- `ack` and first beat in the same cycle: not allowed; the DDR interface guarantees `ack` comes first.
- Timeout abort: `timeout_err` is visible on the cycle DONE is entered.
- `*_reading` is high continuously from grant through DONE; the grant signals are one-hot or zero.

## Test plan
- **Single instruction read.** ins req, addr 0x100, len 4; ack at cycle 3; 4 beats D0..D3.
  - `ic_fifo_din` beat_index 0..3, each with valid bit 1.
  - `ins_reading` low 2 cycles after D3; `dc_fifo_wr_en` never asserted.
- **Simultaneous requests from reset.** ins and data req together.
  - Instruction served first, then data, then instruction again if it is still requesting.
  - Each `rd_burst_addr` matches its own requester.
- **Length 0.** data len 0.
  - 256 beats accepted, beat_index wraps 255 -> DONE, `timeout_err` stays 0.
- **Overflow.** `ic_fifo_full` = 1 during beat 2 of a 4-beat burst.
  - `overflow_err` = 1 from that write onward; the burst completes normally.
- **Stall.** TIMEOUT_CYCLES=16; only 1 beat of 8 delivered.
  - `timeout_err` = 1, 17 cycles after the beat; `ins_reading` falls and the data request is granted next.
- **Reset mid-burst.** `rst` pulse during BURST.
  - Next cycle all outputs are 0 and both errors are 0.
  - A pending instruction request is granted 1 cycle after `rst` falls.
